// File: rtl/bounce_gen.sv
// bounce_gen: contact-bounce emulator. Turns a clean level request into a
// bouncing output that settles on the requested level after a fixed window.
// The window length, segment lengths and the pseudo-random pattern are all set
// by parameters, so a given configuration always produces the same waveform.
// Optional feature: define BOUNCE_GEN_GLITCH_COUNT_EN to add the 8-bit
// 'glitches' output, which counts the out toggles of the last/current bounce.
module bounce_gen #(
    parameter int          C_CLK_FRQ     = 100000000,  // clock frequency [Hz]
    parameter real         C_INTERVAL    = 0.010,      // bounce window [ms]
    parameter int          C_MIN_GLITCH  = 2,          // minimum segment [cycles]
    parameter int          C_GLITCH_BITS = 4,          // random extension width
    parameter logic [15:0] C_SEED        = 16'hACE1    // LFSR reset value
) (
    input  logic       clk,
    input  logic       rstb,     // asynchronous, active-high
    input  logic       in,
    output logic       out,
    output logic       busy,
    output logic       done
`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
    ,
    output logic [7:0] glitches
`endif
);

    // Window length in cycles; the real-to-int cast rounds to nearest.
    localparam int N  = int'(real'(C_CLK_FRQ) * C_INTERVAL / 1000.0);
    localparam int WW = (N > 0) ? $clog2(N + 1) : 1;
    localparam int SW = $clog2(C_MIN_GLITCH + (1 << C_GLITCH_BITS));

    // Field of the LFSR that extends each segment beyond the minimum length.
    localparam logic [15:0] MASK      = 16'((1 << C_GLITCH_BITS) - 1);
    // Taps of x^16+x^14+x^13+x^11+1 for a right-shifting Galois register.
    localparam logic [15:0] TAPS      = 16'hB400;
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] LFSR_INIT = (C_SEED == 16'h0000) ? 16'h0001 : C_SEED;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BOUNCE = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    logic          inMeta;
    logic          inSync;
    logic [1:0]    state;
    logic          target;
    logic [WW-1:0] window;
    logic [SW-1:0] seg;
    logic [15:0]   lfsr;

    logic [SW-1:0] segLoad;
    logic          segHit;
    logic          winEnd;
    logic          retarget;

    assign segLoad  = SW'(C_MIN_GLITCH) + SW'(lfsr & MASK);
    assign segHit   = (seg == SW'(1));
    assign winEnd   = (window == WW'(1));
    assign retarget = (inSync != target);

    assign busy = (state == ST_BOUNCE);
    assign done = (state == ST_SETTLE);

    // Two-flop synchroniser for the asynchronous level request.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            inMeta <= 1'b0;
            inSync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values, giving a real two-stage chain instead of a single wire.
            inMeta <= in;
            inSync <= inMeta;
        end
    end

    // Pattern generator: steps only while bouncing so each bounce is repeatable.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            lfsr <= LFSR_INIT;
        end else if (state == ST_BOUNCE) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
        end
    end

    // Main sequencer: idle -> bounce window -> one settle cycle -> idle.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state  <= ST_IDLE;
            target <= 1'b0;
            out    <= 1'b0;
            window <= '0;
            seg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (retarget) begin
                        target <= inSync;
                        if (N == 0) begin
                            // Zero-length window: follow the request directly.
                            out   <= inSync;
                            state <= ST_SETTLE;
                        end else begin
                            out    <= ~out;
                            window <= WW'(N);
                            seg    <= segLoad;
                            state  <= ST_BOUNCE;
                        end
                    end
                end
                ST_BOUNCE: begin
                    // A new request restarts the window but keeps bouncing.
                    if (retarget) begin
                        target <= inSync;
                        window <= WW'(N);
                    end else begin
                        window <= window - 1'b1;
                    end
                    // Window end forces the target and drops a coinciding toggle.
                    if (!retarget && winEnd) begin
                        out   <= target;
                        state <= ST_SETTLE;
                    end else if (segHit) begin
                        out <= ~out;
                        seg <= segLoad;
                    end else begin
                        seg <= seg - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
    logic       bounceToggle;
    logic [7:0] glitchCnt;

    // Flags an out edge produced by the bounce state in this cycle.
    always_comb begin
        // NOTE: default first, so no path through this block infers a latch.
        bounceToggle = 1'b0;
        if (state == ST_BOUNCE) begin
            if (!retarget && winEnd) begin
                bounceToggle = (out != target);
            end else begin
                bounceToggle = segHit;
            end
        end
    end

    // Toggle counter: starts at 1 for the entry toggle, saturates at 255.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            glitchCnt <= 8'd0;
        end else if (state == ST_IDLE && retarget && N != 0) begin
            glitchCnt <= 8'd1;
        end else if (bounceToggle && glitchCnt != 8'hFF) begin
            glitchCnt <= glitchCnt + 8'd1;
        end
    end

    assign glitches = glitchCnt;
`endif

endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed bench for bounce_gen. Four instances run side by side:
// A = defaults (N=1000), B = N=30 with fixed 2-cycle segments, C = seed 0,
// Z = zero-length window. Expected cycle numbers and segment gaps are worked
// out by hand from the LFSR polynomial and the synchroniser latency.
module tb_bounce_gen;

    logic       clk = 1'b0;
    logic       rstb;
    logic [3:0] inV;
    wire  [3:0] outV;
    wire  [3:0] busyV;
    wire  [3:0] doneV;
`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
    wire  [7:0] glA, glB, glC, glZ;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bounce_gen dutA (
        .clk(clk), .rstb(rstb), .in(inV[0]), .out(outV[0]), .busy(busyV[0]), .done(doneV[0])
`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
        , .glitches(glA)
`endif
    );
    bounce_gen #(.C_INTERVAL(0.0003), .C_MIN_GLITCH(2), .C_GLITCH_BITS(0)) dutB (
        .clk(clk), .rstb(rstb), .in(inV[1]), .out(outV[1]), .busy(busyV[1]), .done(doneV[1])
`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
        , .glitches(glB)
`endif
    );
    bounce_gen #(.C_SEED(16'h0000)) dutC (
        .clk(clk), .rstb(rstb), .in(inV[2]), .out(outV[2]), .busy(busyV[2]), .done(doneV[2])
`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
        , .glitches(glC)
`endif
    );
    bounce_gen #(.C_INTERVAL(0.0)) dutZ (
        .clk(clk), .rstb(rstb), .in(inV[3]), .out(outV[3]), .busy(busyV[3]), .done(doneV[3])
`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
        , .glitches(glZ)
`endif
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Monitor on the falling edge: out edges, done pulses, busy activity.
    logic [3:0] prevOut = '0;
    int doneCnt[4]  = '{default: 0};
    int doneAt[4]   = '{default: -1};
    int busyCnt[4]  = '{default: 0};
    int overlap     = 0;
    int togA[$];
    int togB[$];
    int togC[$];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (doneV[i]) begin
                doneCnt[i]++;
                doneAt[i] = cyc;
            end
            if (busyV[i]) busyCnt[i]++;
            if (busyV[i] && doneV[i]) overlap++;
        end
        if (outV[0] != prevOut[0]) togA.push_back(cyc);
        if (outV[1] != prevOut[1]) togB.push_back(cyc);
        if (outV[2] != prevOut[2]) togC.push_back(cyc);
        prevOut = outV;
    end

    task automatic clearMon();
        for (int i = 0; i < 4; i++) begin
            doneCnt[i] = 0;
            doneAt[i]  = -1;
            busyCnt[i] = 0;
        end
        togA.delete();
        togB.delete();
        togC.delete();
        prevOut = outV;
    endtask

    // Advance n cycles; inputs are driven and outputs sampled 2 ns after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulseReset();
        rstb = 1'b1;
        inV  = '0;
        step(3);
        rstb = 1'b0;
        step(3);
        clearMon();
    endtask

    function automatic int qAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Counts gaps outside [lo,hi], ignoring the forced edge at window end.
    function automatic int gapViol(input int q[$], input int endCyc, input int lo, input int hi);
        int v = 0;
        for (int i = 1; i < q.size(); i++)
            if (q[i] != endCyc && ((q[i] - q[i-1]) < lo || (q[i] - q[i-1]) > hi)) v++;
        return v;
    endfunction

    int e, entry, e2, mism;
    int run1[$];
    int run2[$];

    initial begin
        rstb = 1'b1;
        inV  = '0;
        #100;
        check("reset_out",  int'(outV[0]),  0);
        check("reset_busy", int'(busyV[0]), 0);
        check("reset_done", int'(doneV[0]), 0);
        #100;
        rstb = 1'b0;
        step(1);
        clearMon();

        // Quiet input: nothing moves for 10 us.
        step(1000);
        check("idle_toggles", togA.size() + togB.size() + togC.size(), 0);
        check("idle_busy", busyCnt[0] + busyCnt[1] + busyCnt[2] + busyCnt[3], 0);

        // Default bounce on A, seed-0 bounce on C, zero window on Z.
        e = cyc;
        inV[0] = 1'b1;
        inV[2] = 1'b1;
        inV[3] = 1'b1;
        entry  = e + 3;
        step(2);
        check("a_busy_before_entry", int'(busyV[0]), 0);
        check("z_out_before",        int'(outV[3]),  0);
        step(1);
        check("a_busy_at_entry", int'(busyV[0]), 1);
        check("z_out_after",     int'(outV[3]),  1);
        check("z_done_pulse",    int'(doneV[3]), 1);
        step(1);
        check("z_done_single",   int'(doneV[3]), 0);
        step(999);
        check("a_done_at_window", int'(doneV[0]), 1);
        check("a_busy_at_done",   int'(busyV[0]), 0);
        check("a_out_final",      int'(outV[0]),  1);
        step(5);
        check("a_done_count",  doneCnt[0], 1);
        check("a_done_cycle",  doneAt[0], entry + 1000);
        check("a_first_edge",  qAt(togA, 0), entry);
        check("a_gap1",        qAt(togA, 1) - qAt(togA, 0), 3);
        check("a_gap2",        qAt(togA, 2) - qAt(togA, 1), 10);
        check("a_gap_range",   gapViol(togA, entry + 1000, 2, 17), 0);
        check("c_gap1",        qAt(togC, 1) - qAt(togC, 0), 3);
        check("c_gap2",        qAt(togC, 2) - qAt(togC, 1), 2);
        check("c_not_stuck",   int'(togC.size() > 20), 1);
        check("c_out_final",   int'(outV[2]), 1);
        check("z_busy_never",  busyCnt[3], 0);
        check("z_done_count",  doneCnt[3], 1);
        foreach (togA[i]) run1.push_back(togA[i] - entry);

        // Determinism: identical bounce after reset.
        pulseReset();
        e = cyc;
        inV[0] = 1'b1;
        entry  = e + 3;
        step(1010);
        foreach (togA[i]) run2.push_back(togA[i] - entry);
        check("det_edge_count", run2.size(), run1.size());
        mism = 0;
        for (int i = 0; i < run1.size() && i < run2.size(); i++)
            if (run1[i] != run2[i]) mism++;
        check("det_edge_times", mism, 0);
        check("det_done_cycle", doneAt[0], entry + 1000);

        // Retarget 400 cycles into the bounce: window restarts, one done.
        pulseReset();
        inV[0] = 1'b1;
        step(400);
        e2 = cyc;
        inV[0] = 1'b0;
        step(1010);
        check("rt_done_count", doneCnt[0], 1);
        check("rt_done_cycle", doneAt[0], e2 + 3 + 1000);
        check("rt_out_final",  int'(outV[0]), 0);

        // Asynchronous reset in the middle of a bounce while out is high.
        pulseReset();
        inV[0] = 1'b1;
        step(503);
        for (int k = 0; k < 40 && outV[0] != 1'b1; k++) step(1);
        check("ar_out_high_before", int'(outV[0]), 1);
        rstb = 1'b1;
        #1;
        check("ar_out_cleared",  int'(outV[0]),  0);
        check("ar_busy_cleared", int'(busyV[0]), 0);
        step(3);
        check("ar_no_done", doneCnt[0], 0);
        rstb = 1'b0;
        e = cyc;
        clearMon();
        entry = e + 3;
        step(3);
        check("ar_rebounce_busy", int'(busyV[0]), 1);
        step(1000);
        check("ar_rebounce_done", int'(doneV[0]), 1);
        check("ar_rebounce_out",  int'(outV[0]),  1);

        // Short window with fixed 2-cycle segments on B.
        pulseReset();
        e = cyc;
        inV[1] = 1'b1;
        entry  = e + 3;
        step(40);
        check("b_edge_count", togB.size(), 15);
        check("b_first_edge", qAt(togB, 0), entry);
        check("b_gap_two",    gapViol(togB, -1, 2, 2), 0);
        check("b_done_cycle", doneAt[1], entry + 30);
        check("b_out_final",  int'(outV[1]), 1);
`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
        check("b_glitches",      int'(glB), togB.size());
        step(10);
        check("b_glitches_hold", int'(glB), 15);
`endif

        check("done_busy_exclusive", overlap, 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
Name: bounce_gen

Overview:
Synthesizable contact-bounce emulator: converts a clean level request into a bouncing output, the inverse of the debouncer.
Drives the debounce input in on-board self-test and hardware-in-loop runs of the traffic-light button path; no external button needed.
Bounce window length, glitch widths and pseudo-random pattern are parameterised, so runs are repeatable.

Parameters:
C_CLK_FRQ, 100000000, main clock frequency [Hz].
C_INTERVAL, 0.010, bounce window [ms]; window cycles N = round(C_CLK_FRQ * C_INTERVAL / 1000).
C_MIN_GLITCH, 2, minimum segment length between output toggles [cycles], >= 1.
C_GLITCH_BITS, 4, random extension width; segment length = C_MIN_GLITCH + lfsr[C_GLITCH_BITS-1:0], range 2..17 by default.
C_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.

Ports:
clk  in  1  main clock, rising edge.
rstb  in  1  reset, asynchronous, active-high (asserted = 1).
in  in  1  clean requested level (e.g. from switch/PS register).
out  out  1  bouncing emulated contact signal.
busy  out  1  high while in BOUNCE.
done  out  1  one-cycle pulse when out has settled to the target.
glitches  out  8  toggle count of last/current bounce (only with BOUNCE_GEN_GLITCH_COUNT_EN).

Behaviour:
- Reset: out=0, busy=0, done=0, target=0, state=IDLE, LFSR=C_SEED (or 1), seg/window counters=0, glitches=0. All state flops asynchronously reset.
- in is sampled through a 2-flop synchroniser; all references to in below mean the synchronised value (2-cycle input latency).
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle in BOUNCE only; holds otherwise.
- State IDLE: busy=0. If in != target: target<=in, window<=N, out<=~out (first toggle next cycle), seg<=C_MIN_GLITCH+lfsr field, go BOUNCE.
- State BOUNCE: busy=1; window decrements each cycle; seg decrements; at seg==1 out toggles and seg reloads from LFSR.
- Retarget: if in != target during BOUNCE: target<=in, window reloads to N, bouncing continues (no return to IDLE).
- Window end (window==1): out<=target regardless of toggle phase, go SETTLE.
- State SETTLE: one cycle, done=1, busy=0, then IDLE. in != target in SETTLE is handled in the following IDLE cycle.
- N==0 (degenerate): no BOUNCE; out<=in one cycle after synchroniser, done pulses on that cycle.
- Window counter width = $clog2(N+1); seg counter width = $clog2(C_MIN_GLITCH + 2^C_GLITCH_BITS).
- Toggle suppression: a segment toggle coinciding with window end is dropped; the final value is always target.
- Reset mid-bounce: out returns to 0 immediately, done not pulsed.
- done and busy are never high in the same cycle.

Optional Feature:
Macro BOUNCE_GEN_GLITCH_COUNT_EN.
- Defined: port glitches present. Cleared when entering BOUNCE; counts every out toggle including the first and the final forced edge when it changes out; saturates at 255; holds after SETTLE until the next BOUNCE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: rstb=1 for 200 ns, then in=0 -> out=0, busy=0, done=0; no toggles for 10 us.
- Defaults (N=1000): in 0->1 -> busy rises 3 cycles after the in edge. out toggles with every gap in 2..17 cycles. out=1 exactly 1000 cycles after BOUNCE entry; done single pulse; busy falls.
- Retarget: in 0->1, then 1->0 after 400 cycles -> window restarts. Final out=0 at 1000 cycles after the second synchronised edge; exactly one done pulse.
- Determinism: two runs with C_SEED=16'hACE1 -> identical out waveform. C_SEED=0 -> behaves as seed 1, out not stuck.
- Async reset at cycle 500 of a bounce -> out=0, busy=0 within the same cycle, no done. After release, in=1 starts a fresh 1000-cycle bounce.
- With BOUNCE_GEN_GLITCH_COUNT_EN, C_INTERVAL=0.0003 (N=30), C_MIN_GLITCH=2, C_GLITCH_BITS=0 -> out toggles every 2 cycles; glitches = bench-counted out edges; glitches holds value after done.
